// File: rtl/seg_sequencer.sv
// rtl/seg_sequencer.sv - phase sequencer for the segmented CPU datapath
//
// Drives one enable strobe per segment (IF, ID, EX, MEM, WB). Each
// instruction class runs only the phases it needs. Also handshakes with
// instruction/data memory and owns the register-file and PC write strobes.
//
// Optional feature: define SEQ_PERF_CNT_EN to build the cycle/retire
// performance counters; otherwise cycle_cnt/retire_cnt are tied to 0.
//
// Ports:
//   clk                      system clock, rising edge
//   rst                      asynchronous active-low reset
//   is_load .. is_halt       class flags for the instruction in ID
//   imem_ready, dmem_ready   memory access complete
//   if_en .. wb_en           segment enables (one-hot, none in HALT)
//   imem_req, dmem_req       memory requests (mirror if_en / mem_en)
//   wb_write, pc_write       register-file and PC update strobes
//   mem_err                  one-cycle pulse on memory timeout
//   halted                   high in HALT
//   phase                    state code IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5
//   cycle_cnt, retire_cnt    performance counters

`timescale 1ns/1ps

module seg_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_alur,
  input  logic        is_aluimm,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_halt,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        wb_write,
  output logic        pc_write,
  output logic        mem_err,
  output logic        halted,
  output logic [2:0]  phase,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // alur and aluimm share a path, as do branch and jump.
  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_BRJ   = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_ALU   = 3'd4,
    C_HALT  = 3'd5
  } class_t;

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  class_t     cls, cls_dec;
  logic [7:0] wait_cnt, wait_nxt;
  logic       waiting, timeout;

  always_comb begin
    cls_dec = C_NONE;
    if (is_halt)                  cls_dec = C_HALT;
    else if (is_branch || is_jump) cls_dec = C_BRJ;
    else if (is_load)             cls_dec = C_LOAD;
    else if (is_store)            cls_dec = C_STORE;
    else if (is_alur || is_aluimm) cls_dec = C_ALU;
  end

  // The wait counter holds the number of ready-low cycles already spent in
  // the current IF/MEM visit; ready in the limit cycle still wins.
  assign waiting = ((state == S_IF) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign timeout = waiting && (wait_cnt == LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF: begin
        if (imem_ready) state_nxt = S_ID;
        else if (timeout) state_nxt = S_IF;
      end
      S_ID:  state_nxt = (cls_dec == C_HALT) ? S_HALT : S_EX;
      S_EX: begin
        case (cls)
          C_ALU:            state_nxt = S_WB;
          C_LOAD, C_STORE:  state_nxt = S_MEM;
          default:          state_nxt = S_IF;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) state_nxt = (cls == C_LOAD) ? S_WB : S_IF;
        else if (timeout) state_nxt = S_IF;
      end
      S_WB:    state_nxt = S_IF;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Every exit from IF/MEM (and every other state) leaves the counter at 0,
  // so each new IF/MEM visit starts counting from zero.
  assign wait_nxt = (waiting && !timeout) ? wait_cnt + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IF;
      cls      <= C_NONE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_ID) cls <= cls_dec;
    end
  end

  assign if_en    = (state == S_IF);
  assign id_en    = (state == S_ID);
  assign ex_en    = (state == S_EX);
  assign mem_en   = (state == S_MEM);
  assign wb_en    = (state == S_WB);
  assign imem_req = if_en;
  assign dmem_req = mem_en;
  assign halted   = (state == S_HALT);
  assign phase    = state;
  assign wb_write = (state == S_WB);
  assign mem_err  = timeout;

  // Retire points: EX for branch/jump/none, MEM completion for store, WB
  // for load and ALU. A timed-out store never sees dmem_ready here.
  assign pc_write = ((state == S_EX) && ((cls == C_BRJ) || (cls == C_NONE)))
                 || ((state == S_MEM) && (cls == C_STORE) && dmem_ready)
                 || (state == S_WB);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      if (state != S_HALT) cyc_q <= cyc_q + 32'd1;
      if (pc_write)        ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
`else
  assign cycle_cnt  = 32'd0;
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_seg_sequencer.sv
// tb/tb_seg_sequencer.sv - self-checking bench for seg_sequencer

`timescale 1ns/1ps

module tb_seg_sequencer;

  localparam int TO = 15;
  localparam logic [2:0] P_IF = 3'd0, P_ID = 3'd1, P_EX = 3'd2, P_MEM = 3'd3, P_WB = 3'd4, P_HALT = 3'd5;
  localparam int K_NONE = 0, K_BRJ = 1, K_LOAD = 2, K_STORE = 3, K_ALU = 4, K_HALT = 5;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // flag bit order: 0 load, 1 store, 2 alur, 3 aluimm, 4 branch, 5 jump, 6 halt
  logic        clk, rst, imem_ready, dmem_ready;
  logic [6:0]  flags;
  logic        is_load, is_store, is_alur, is_aluimm, is_branch, is_jump, is_halt;
  logic        if_en, id_en, ex_en, mem_en, wb_en, imem_req, dmem_req;
  logic        wb_write, pc_write, mem_err, halted;
  logic [2:0]  phase;
  logic [31:0] cycle_cnt, retire_cnt;

  assign {is_halt, is_jump, is_branch, is_aluimm, is_alur, is_store, is_load} = flags;

  seg_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .is_load(is_load), .is_store(is_store), .is_alur(is_alur), .is_aluimm(is_aluimm),
    .is_branch(is_branch), .is_jump(is_jump), .is_halt(is_halt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .imem_req(imem_req), .dmem_req(dmem_req), .wb_write(wb_write), .pc_write(pc_write),
    .mem_err(mem_err), .halted(halted), .phase(phase),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    bit         ir;
    bit         dr;
    bit         wb;
    bit         pc;
    bit         err;
    logic [6:0] fl;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cyc, exp_ret, cur_cyc, cur_ret;

  wire [13:0] obs_vec = {phase, if_en, id_en, ex_en, mem_en, wb_en, imem_req, dmem_req,
                         wb_write, pc_write, mem_err, halted};

  function automatic logic [13:0] exp_vec(ent_t e);
    return {e.ph, e.ph == P_IF, e.ph == P_ID, e.ph == P_EX, e.ph == P_MEM, e.ph == P_WB,
            e.ph == P_IF, e.ph == P_MEM, e.wb, e.pc, e.err, e.ph == P_HALT};
  endfunction

  function automatic int class_of(logic [6:0] f);
    if (f[6])             return K_HALT;
    if (f[4] || f[5])     return K_BRJ;
    if (f[0])             return K_LOAD;
    if (f[1])             return K_STORE;
    if (f[2] || f[3])     return K_ALU;
    return K_NONE;
  endfunction

  // One expected cycle; unused inputs get random values.
  function automatic ent_t mk(logic [2:0] ph);
    ent_t e;
    e.ph = ph; e.ir = 1'($urandom); e.dr = 1'($urandom);
    e.wb = 1'b0; e.pc = 1'b0; e.err = 1'b0; e.fl = 7'($urandom);
    return e;
  endfunction

  // A memory wait: ready rises after `delay` low cycles, unless TO low
  // cycles pass first, in which case the next low cycle is the abort.
  task automatic push_wait(input logic [2:0] ph, input int delay, input bit retire, output bit ok);
    bit done;
    ent_t e;
    done = 1'b0; ok = 1'b0;
    for (int k = 0; k <= TO && !done; k++) begin
      e = mk(ph);
      if (ph == P_IF) e.ir = (k >= delay); else e.dr = (k >= delay);
      e.pc  = (k >= delay) && retire;
      e.err = (k < delay) && (k == TO);
      q.push_back(e);
      if (k >= delay || e.err) begin done = 1'b1; ok = (k >= delay); end
    end
  endtask

  task automatic build_instr(input logic [6:0] f, input int idel, input int ddel);
    bit ok;
    ent_t e;
    int k;
    push_wait(P_IF, idel, 1'b0, ok);
    if (!ok) return;
    e = mk(P_ID); e.fl = f; q.push_back(e);
    k = class_of(f);
    if (k == K_HALT) return;
    e = mk(P_EX); e.pc = (k == K_BRJ || k == K_NONE); q.push_back(e);
    if (k == K_ALU) begin
      e = mk(P_WB); e.wb = 1'b1; e.pc = 1'b1; q.push_back(e);
    end else if (k == K_LOAD || k == K_STORE) begin
      push_wait(P_MEM, ddel, k == K_STORE, ok);
      if (ok && k == K_LOAD) begin
        e = mk(P_WB); e.wb = 1'b1; e.pc = 1'b1; q.push_back(e);
      end
    end
  endtask

  // Apply one cycle of stimulus after the falling edge; outputs are
  // observed 1ns later. cur_* are the counter values due this cycle.
  task automatic drive(input ent_t e);
    @(negedge clk);
    imem_ready = e.ir; dmem_ready = e.dr; flags = e.fl;
    #1;
    cur_cyc = PERF ? exp_cyc : 32'd0;
    cur_ret = PERF ? exp_ret : 32'd0;
    if (e.ph != P_HALT) exp_cyc = exp_cyc + 32'd1;
    if (e.pc)           exp_ret = exp_ret + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; flags = 7'd0;
    @(posedge clk);
    #2 rst = 1'b1;
    exp_cyc = 32'd0; exp_ret = 32'd0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; flags = 7'd0;
    #3;
    checks++;
    if (obs_vec !== 14'b000_1000010_0000) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs_vec, 14'b000_1000010_0000);
    end
    checks++;
    if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, retire_cnt);
    end
    imem_ready = 1'b1; flags = 7'h7f;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (phase !== P_IF || pc_write !== 1'b0) begin
      errors++; $display("FAIL reset_held: got phase %0d pc %b want 0 0", phase, pc_write);
    end
    do_reset();
  endtask

  task automatic test_alur();
    ent_t e;
    do_reset();
    build_instr(7'b0000100, 0, 0);
    while (q.size() > 0) begin
      e = q.pop_front(); drive(e);
      checks++;
      if (obs_vec !== exp_vec(e)) begin
        errors++; $display("FAIL alur_cycle: got %b want %b", obs_vec, exp_vec(e));
      end
    end
    e = mk(P_IF); e.ir = 1'b0; drive(e);
    checks++;
    if (phase !== P_IF || retire_cnt !== 32'(PERF) || wb_write !== 1'b0) begin
      errors++; $display("FAIL alur_after: got phase %0d retire %0d wb %b want 0 %0d 0", phase, retire_cnt, wb_write, PERF);
    end
  endtask

  task automatic test_load_wait();
    ent_t e;
    int n_mem, n_wb;
    n_mem = 0; n_wb = 0;
    do_reset();
    build_instr(7'b0000001, 0, 3);
    while (q.size() > 0) begin
      e = q.pop_front(); drive(e);
      if (phase === P_MEM) n_mem++;
      if (wb_write === 1'b1) n_wb++;
      checks++;
      if (obs_vec !== exp_vec(e)) begin
        errors++; $display("FAIL load_cycle: got %b want %b", obs_vec, exp_vec(e));
      end
    end
    checks++;
    if (n_mem != 4 || n_wb != 1) begin
      errors++; $display("FAIL load_counts: got mem %0d wb %0d want 4 1", n_mem, n_wb);
    end
    e = mk(P_IF); e.ir = 1'b0; drive(e);
    checks++;
    if (cycle_cnt !== (PERF ? 32'd8 : 32'd0) || retire_cnt !== 32'(PERF)) begin
      errors++; $display("FAIL load_perf: got %0d/%0d want %0d/%0d", cycle_cnt, retire_cnt, PERF ? 8 : 0, PERF);
    end
  endtask

  task automatic test_store_timeout();
    ent_t e;
    int n_err, n_pc;
    for (int pass = 0; pass < 2; pass++) begin
      n_err = 0; n_pc = 0;
      do_reset();
      // pass 0: ready never comes; pass 1: ready arrives in the limit cycle
      build_instr(7'b0000010, 0, (pass == 0) ? 1000 : TO);
      while (q.size() > 0) begin
        e = q.pop_front(); drive(e);
        if (mem_err === 1'b1) n_err++;
        if (pc_write === 1'b1) n_pc++;
        checks++;
        if (obs_vec !== exp_vec(e)) begin
          errors++; $display("FAIL store_cycle%0d: got %b want %b", pass, obs_vec, exp_vec(e));
        end
      end
      checks++;
      if (n_err != 1 - pass || n_pc != pass) begin
        errors++; $display("FAIL store_strobes%0d: got err %0d pc %0d want %0d %0d", pass, n_err, n_pc, 1 - pass, pass);
      end
      e = mk(P_IF); e.ir = 1'b0; drive(e);
      checks++;
      if (phase !== P_IF || retire_cnt !== (PERF ? 32'(pass) : 32'd0)) begin
        errors++; $display("FAIL store_after%0d: got phase %0d retire %0d want 0 %0d", pass, phase, retire_cnt, PERF ? pass : 0);
      end
    end
  endtask

  task automatic test_branch_priority();
    ent_t e;
    logic [6:0] fl[2];
    fl[0] = 7'b0010001;
    fl[1] = 7'b0100110;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      build_instr(fl[i], 0, 0);
      while (q.size() > 0) begin
        e = q.pop_front(); drive(e);
        checks++;
        if (obs_vec !== exp_vec(e)) begin
          errors++; $display("FAIL branch_cycle%0d: got %b want %b", i, obs_vec, exp_vec(e));
        end
      end
      e = mk(P_IF); e.ir = 1'b0; drive(e);
      checks++;
      if (phase !== P_IF || mem_en !== 1'b0 || wb_en !== 1'b0) begin
        errors++; $display("FAIL branch_after%0d: got phase %0d want 0", i, phase);
      end
    end
  endtask

  task automatic test_halt();
    ent_t e;
    do_reset();
    build_instr(7'b1000000 | (7'($urandom) & 7'h3f), 1, 0);
    repeat (20) q.push_back(mk(P_HALT));
    while (q.size() > 0) begin
      e = q.pop_front(); drive(e);
      checks++;
      if (obs_vec !== exp_vec(e) || cycle_cnt !== cur_cyc) begin
        errors++; $display("FAIL halt_cycle: got %b cyc %0d want %b cyc %0d", obs_vec, cycle_cnt, exp_vec(e), cur_cyc);
      end
    end
    checks++;
    if (cycle_cnt !== (PERF ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL halt_frozen: got %0d want %0d", cycle_cnt, PERF ? 3 : 0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (phase !== P_IF || halted !== 1'b0 || if_en !== 1'b1) begin
      errors++; $display("FAIL halt_exit: got phase %0d halted %b want 0 0", phase, halted);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    ent_t e;
    do_reset();
    build_instr(7'b0000001, 0, 10);
    for (int i = 0; i < 5; i++) begin
      e = q.pop_front(); drive(e);
      checks++;
      if (obs_vec !== exp_vec(e)) begin
        errors++; $display("FAIL rstmem_cycle: got %b want %b", obs_vec, exp_vec(e));
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (phase !== P_IF || if_en !== 1'b1 || wb_write !== 1'b0 || pc_write !== 1'b0 ||
        cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errors++; $display("FAIL rstmem_async: got phase %0d wb %b cyc %0d ret %0d want 0 0 0 0", phase, wb_write, cycle_cnt, retire_cnt);
    end
    dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (phase !== P_IF || wb_write !== 1'b0) begin
      errors++; $display("FAIL rstmem_held: got phase %0d wb %b want 0 0", phase, wb_write);
    end
    do_reset();
    e = mk(P_IF); e.ir = 1'b0; drive(e);
    checks++;
    if (phase !== P_IF || wb_write !== 1'b0 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errors++; $display("FAIL rstmem_after: got phase %0d wb %b cyc %0d want 0 0 0", phase, wb_write, cycle_cnt);
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    logic [6:0] f;
    int idel, ddel, r;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      f = 7'd0;
      r = $urandom_range(0, 6);
      if (r > 0) f[r - 1] = 1'b1;
      if ($urandom_range(0, 3) == 0) f = f | (7'($urandom) & 7'h3f);
      r = $urandom_range(0, 19);
      idel = (r < 16) ? $urandom_range(0, 2) : ((r < 18) ? TO : TO + 1);
      r = $urandom_range(0, 19);
      ddel = (r < 14) ? $urandom_range(0, 3) : ((r < 17) ? TO : TO + 1 + $urandom_range(0, 4));
      build_instr(f, idel, ddel);
      while (q.size() > 0) begin
        e = q.pop_front(); drive(e);
        checks++;
        if (obs_vec !== exp_vec(e)) begin
          errors++; $display("FAIL b2b_strobes n=%0d: got %b want %b", n, obs_vec, exp_vec(e));
        end
        checks++;
        if (cycle_cnt !== cur_cyc || retire_cnt !== cur_ret) begin
          errors++; $display("FAIL b2b_counters n=%0d: got %0d/%0d want %0d/%0d", n, cycle_cnt, retire_cnt, cur_cyc, cur_ret);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_cyc = 32'd0; exp_ret = 32'd0; cur_cyc = 32'd0; cur_ret = 32'd0;
    test_reset();
    test_alur();
    test_load_wait();
    test_store_timeout();
    test_branch_priority();
    test_halt();
    test_reset_mid_mem();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
